fft_stage_sched: RTL and testbench

FFT_STAGE_SCHED -- requirements
Module: fft_stage_sched

---
 rtl/fft_stage_sched_if.sv | 42 ++++
 rtl/fft_stage_sched.sv | 142 ++++++++++++++
 tb/tb_fft_stage_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_stage_sched_if : serial in/out, butterfly issue/return bundle          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fft_stage_sched_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 10
);
  logic                    i_vld;
  logic                    o_rdy;
  logic signed [IN_W-1:0]  i_I;
  logic signed [IN_W-1:0]  i_Q;
  logic                    o_bf_vld;
  logic signed [IN_W-1:0]  o_bf_LI;
  logic signed [IN_W-1:0]  o_bf_LQ;
  logic signed [IN_W-1:0]  o_bf_RI;
  logic signed [IN_W-1:0]  o_bf_RQ;
  logic                    i_bf_vld;
  logic signed [OUT_W-1:0] i_bf_LI;
  logic signed [OUT_W-1:0] i_bf_LQ;
  logic signed [OUT_W-1:0] i_bf_RI;
  logic signed [OUT_W-1:0] i_bf_RQ;
  logic                    o_vld;
  logic signed [OUT_W-1:0] o_I;
  logic signed [OUT_W-1:0] o_Q;
  logic                    o_sof;
  logic                    o_err;

  modport slave (
    input  i_vld, i_I, i_Q, i_bf_vld, i_bf_LI, i_bf_LQ, i_bf_RI, i_bf_RQ,
    output o_rdy, o_bf_vld, o_bf_LI, o_bf_LQ, o_bf_RI, o_bf_RQ,
           o_vld, o_I, o_Q, o_sof, o_err
  );

  modport master (
    output i_vld, i_I, i_Q, i_bf_vld, i_bf_LI, i_bf_LQ, i_bf_RI, i_bf_RQ,
    input  o_rdy, o_bf_vld, o_bf_LI, o_bf_LQ, o_bf_RI, o_bf_RQ,
           o_vld, o_I, o_Q, o_sof, o_err
  );
endinterface
`default_nettype wire

// File: rtl/fft_stage_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_stage_sched : radix-2 stage scheduler (delay RAM, pair issue, drain)   |
// | Optional macro FFT_STAGE_SCHED_STATS_EN adds o_hold_cnt.    Rev 1.0        |
// +----------------------------------------------------------------------------+
module fft_stage_sched #(
  parameter int IN_W    = 10,
  parameter int OUT_W   = 10,
  parameter int FFT_LEN = 256
) (
  input  wire logic         mclk,
  input  wire logic         i_init_n,
  fft_stage_sched_if.slave  bus
`ifdef FFT_STAGE_SCHED_STATS_EN
  ,
  output logic [15:0]       o_hold_cnt
`endif
);
  localparam int H  = FFT_LEN / 2;
  localparam int AW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = $clog2(H + 1);
  localparam logic [AW-1:0] c_IDX_LAST = AW'(H - 1);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAIR = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [AW-1:0] r_idx, r_lcnt, r_rwr, r_didx;
  logic [CW-1:0] r_outst;
  logic          r_drain, r_rdy;
  logic          r_bf_vld, r_vld, r_sof, r_err;

  logic signed [IN_W-1:0]  r_ram_I  [H];
  logic signed [IN_W-1:0]  r_ram_Q  [H];
  logic signed [OUT_W-1:0] r_rbuf_I [H];
  logic signed [OUT_W-1:0] r_rbuf_Q [H];
  logic signed [IN_W-1:0]  r_bf_LI, r_bf_LQ, r_bf_RI, r_bf_RQ;
  logic signed [OUT_W-1:0] r_o_I, r_o_Q;

  logic w_acc, w_issue, w_ret_ok, w_drain_start;

  assign w_acc         = bus.i_vld & r_rdy;
  assign w_issue       = w_acc & (r_state == S_PAIR);
  assign w_ret_ok      = bus.i_bf_vld & (r_outst != '0);
  assign w_drain_start = w_ret_ok & (r_lcnt == c_IDX_LAST);

  // Only an already running drain forces HOLD: with a fixed butterfly latency the
  // next frame's L results always land after a drain that starts later.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: if (w_acc && r_idx == c_IDX_LAST) w_state_nxt = r_drain ? S_HOLD : S_PAIR;
      S_PAIR: if (w_acc && r_idx == c_IDX_LAST) w_state_nxt = S_FILL;
      S_HOLD: if (!r_drain) w_state_nxt = S_PAIR;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!i_init_n) begin
      r_state  <= S_FILL;
      r_rdy    <= 1'b0;
      r_idx    <= '0;
      r_lcnt   <= '0;
      r_rwr    <= '0;
      r_didx   <= '0;
      r_outst  <= '0;
      r_drain  <= 1'b0;
      r_bf_vld <= 1'b0;
      r_vld    <= 1'b0;
      r_sof    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy    <= (w_state_nxt != S_HOLD);
      r_bf_vld <= w_issue;
      r_err    <= bus.i_bf_vld & (r_outst == '0);
      r_vld    <= w_ret_ok | r_drain;
      r_sof    <= w_ret_ok & (r_lcnt == '0);
      if (w_acc) r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
      if (w_issue && !w_ret_ok)      r_outst <= r_outst + 1'b1;
      else if (!w_issue && w_ret_ok) r_outst <= r_outst - 1'b1;
      if (w_ret_ok) begin
        r_lcnt <= (r_lcnt == c_IDX_LAST) ? '0 : r_lcnt + 1'b1;
        r_rwr  <= (r_rwr == c_IDX_LAST) ? '0 : r_rwr + 1'b1;
      end
      if (w_drain_start) begin
        r_drain <= 1'b1;
        r_didx  <= '0;
      end else if (r_drain) begin
        r_didx <= (r_didx == c_IDX_LAST) ? '0 : r_didx + 1'b1;
        if (r_didx == c_IDX_LAST) r_drain <= 1'b0;
      end
    end
  end

  // Datapath storage is never reset; stale entries are unreachable once indices clear.
  always_ff @(posedge mclk) begin
    if (w_acc && r_state == S_FILL) begin
      r_ram_I[r_idx] <= bus.i_I;
      r_ram_Q[r_idx] <= bus.i_Q;
    end
    if (w_issue) begin
      r_bf_LI <= r_ram_I[r_idx];
      r_bf_LQ <= r_ram_Q[r_idx];
      r_bf_RI <= bus.i_I;
      r_bf_RQ <= bus.i_Q;
    end
    if (w_ret_ok) begin
      r_rbuf_I[r_rwr] <= bus.i_bf_RI;
      r_rbuf_Q[r_rwr] <= bus.i_bf_RQ;
      r_o_I           <= bus.i_bf_LI;
      r_o_Q           <= bus.i_bf_LQ;
    end else if (r_drain) begin
      r_o_I <= r_rbuf_I[r_didx];
      r_o_Q <= r_rbuf_Q[r_didx];
    end
  end

`ifdef FFT_STAGE_SCHED_STATS_EN
  logic [15:0] r_hold_cnt;
  always_ff @(posedge mclk) begin
    if (!i_init_n)                                      r_hold_cnt <= 16'd0;
    else if (r_state == S_HOLD && r_hold_cnt != 16'hFFFF) r_hold_cnt <= r_hold_cnt + 16'd1;
  end
  assign o_hold_cnt = r_hold_cnt;
`endif

  assign bus.o_rdy    = r_rdy;
  assign bus.o_bf_vld = r_bf_vld;
  assign bus.o_bf_LI  = r_bf_LI;
  assign bus.o_bf_LQ  = r_bf_LQ;
  assign bus.o_bf_RI  = r_bf_RI;
  assign bus.o_bf_RQ  = r_bf_RQ;
  assign bus.o_vld    = r_vld;
  assign bus.o_I      = r_o_I;
  assign bus.o_Q      = r_o_Q;
  assign bus.o_sof    = r_sof;
  assign bus.o_err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_stage_sched : directed/random bench with frame-level reference model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fft_stage_sched;
  localparam int IN_W    = 10;
  localparam int OUT_W   = 10;
  localparam int FFT_LEN = 8;
  localparam int H       = FFT_LEN / 2;

  typedef struct packed {
    logic [IN_W-1:0] li, lq, ri, rq;
  } pair_t;
  typedef struct packed {
    logic [OUT_W-1:0] i, q;
  } samp_t;

  logic mclk = 1'b0;
  logic i_init_n;
  always #5 mclk = ~mclk;

  fft_stage_sched_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef FFT_STAGE_SCHED_STATS_EN
  logic [15:0] hold_cnt;
`endif

  fft_stage_sched #(.IN_W(IN_W), .OUT_W(OUT_W), .FFT_LEN(FFT_LEN)) u_dut (
    .mclk     (mclk),
    .i_init_n (i_init_n),
    .bus      (bus)
`ifdef FFT_STAGE_SCHED_STATS_EN
    ,
    .o_hold_cnt (hold_cnt)
`endif
  );

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Butterfly emulator: fixed latency, optional sum/difference so L/R swaps show up.
  int   bf_dly = 0;
  bit   bf_mix = 1'b0;
  logic inj_vld = 1'b0;
  logic [OUT_W-1:0] inj_d = '0;

  function automatic logic [OUT_W-1:0] bf_l(input logic [IN_W-1:0] l, r, input bit mix);
    return mix ? OUT_W'(l + r) : OUT_W'(l);
  endfunction
  function automatic logic [OUT_W-1:0] bf_r(input logic [IN_W-1:0] l, r, input bit mix);
    return mix ? OUT_W'(l - r) : OUT_W'(r);
  endfunction

  logic            pv  [16];
  logic [IN_W-1:0] pli [16];
  logic [IN_W-1:0] plq [16];
  logic [IN_W-1:0] pri [16];
  logic [IN_W-1:0] prq [16];

  always @(posedge mclk) begin
    if (!i_init_n) begin
      for (int i = 0; i < 16; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= bus.o_bf_vld; pli[0] <= bus.o_bf_LI; plq[0] <= bus.o_bf_LQ;
      pri[0] <= bus.o_bf_RI; prq[0] <= bus.o_bf_RQ;
      for (int i = 1; i < 16; i++) begin
        pv[i] <= pv[i-1]; pli[i] <= pli[i-1]; plq[i] <= plq[i-1];
        pri[i] <= pri[i-1]; prq[i] <= prq[i-1];
      end
    end
  end

  logic            s_v;
  logic [IN_W-1:0] s_li, s_lq, s_ri, s_rq;
  always_comb begin
    if (bf_dly == 0) begin
      s_v = bus.o_bf_vld; s_li = bus.o_bf_LI; s_lq = bus.o_bf_LQ;
      s_ri = bus.o_bf_RI; s_rq = bus.o_bf_RQ;
    end else begin
      s_v = pv[bf_dly-1]; s_li = pli[bf_dly-1]; s_lq = plq[bf_dly-1];
      s_ri = pri[bf_dly-1]; s_rq = prq[bf_dly-1];
    end
  end

  assign bus.i_bf_vld = s_v | inj_vld;
  assign bus.i_bf_LI  = inj_vld ? inj_d : bf_l(s_li, s_ri, bf_mix);
  assign bus.i_bf_LQ  = inj_vld ? inj_d : bf_l(s_lq, s_rq, bf_mix);
  assign bus.i_bf_RI  = inj_vld ? inj_d : bf_r(s_li, s_ri, bf_mix);
  assign bus.i_bf_RQ  = inj_vld ? inj_d : bf_r(s_lq, s_rq, bf_mix);

  // Reference model: each 2H-sample frame x gives pairs (x[k], x[k+H]) and the
  // output stream bfL(pair 0..H-1) followed by bfR(pair 0..H-1).
  pair_t exp_pairs[$];
  samp_t exp_out[$];
  samp_t rtmp[$];
  logic [IN_W-1:0] m_i [H];
  logic [IN_W-1:0] m_q [H];
  int  pos = 0, out_pos = 0, cyc = 0;
  int  n_out = 0, first_out = -1, last_out = -1, err_cnt = 0, rdy_low = 0;
  bit  bf_expect = 1'b0;
  logic init_d = 1'b0;

  always @(negedge mclk) begin
    cyc++;
    if (!i_init_n) begin
      exp_pairs.delete(); exp_out.delete(); rtmp.delete();
      pos = 0; out_pos = 0; bf_expect = 1'b0;
    end else begin
      if (bus.o_bf_vld || bf_expect) chk("bf_vld_timing", bus.o_bf_vld, bf_expect);
      if (bus.o_bf_vld) begin
        if (exp_pairs.size() == 0) chk("bf_extra", bus.o_bf_vld, 1'b0);
        else chk("bf_pair", {bus.o_bf_LI, bus.o_bf_LQ, bus.o_bf_RI, bus.o_bf_RQ},
                 exp_pairs.pop_front());
      end
      bf_expect = 1'b0;
      if (bus.i_vld && bus.o_rdy) begin
        if (pos < H) begin
          m_i[pos] = bus.i_I; m_q[pos] = bus.i_Q;
        end else begin
          int k;
          k = pos - H;
          exp_pairs.push_back({m_i[k], m_q[k], bus.i_I, bus.i_Q});
          bf_expect = 1'b1;
          exp_out.push_back({bf_l(m_i[k], bus.i_I, bf_mix), bf_l(m_q[k], bus.i_Q, bf_mix)});
          rtmp.push_back({bf_r(m_i[k], bus.i_I, bf_mix), bf_r(m_q[k], bus.i_Q, bf_mix)});
          if (k == H - 1) begin
            while (rtmp.size() != 0) exp_out.push_back(rtmp.pop_front());
          end
        end
        pos = (pos + 1) % (2 * H);
      end
      if (bus.o_vld) begin
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (exp_out.size() == 0) chk("out_extra", bus.o_vld, 1'b0);
        else begin
          chk("out_data", {bus.o_I, bus.o_Q}, exp_out.pop_front());
          chk("out_sof", bus.o_sof, (out_pos == 0));
          out_pos = (out_pos + 1) % (2 * H);
        end
      end else if (bus.o_sof) chk("sof_no_vld", bus.o_sof, 1'b0);
      if (init_d && !bus.o_rdy) rdy_low++;
    end
    if (bus.o_err) err_cnt++;
    init_d = i_init_n;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic put(input logic [IN_W-1:0] di, input logic [IN_W-1:0] dq);
    int w;
    w = 0;
    bus.i_vld = 1'b1; bus.i_I = di; bus.i_Q = dq;
    @(negedge mclk);
    while (!bus.o_rdy && w < 200) begin
      w++;
      @(negedge mclk);
    end
    if (w >= 200) chk("rdy_timeout", w, 0);
    @(posedge mclk); #1;
    bus.i_vld = 1'b0;
  endtask

  task automatic put_rand(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(1) == 1) idle(1);
      put(IN_W'($urandom), IN_W'($urandom));
    end
  endtask

  task automatic wait_quiet();
    int w;
    w = 0;
    while ((exp_out.size() != 0 || exp_pairs.size() != 0) && w < 600) begin
      idle(1);
      w++;
    end
    chk("drain_timeout", (w < 600), 1'b1);
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, hb;
    i_init_n = 1'b0;
    bus.i_vld = 1'b0; bus.i_I = '0; bus.i_Q = '0;

    // Reset state, including a return arriving during reset.
    idle(2);
    inj_vld = 1'b1; inj_d = OUT_W'($urandom);
    idle(1);
    inj_vld = 1'b0;
    @(negedge mclk);
    chk("rst_rdy", bus.o_rdy, 1'b0);
    chk("rst_bf_vld", bus.o_bf_vld, 1'b0);
    chk("rst_vld", bus.o_vld, 1'b0);
    chk("rst_sof", bus.o_sof, 1'b0);
    chk("rst_err", bus.o_err, 1'b0);
    @(posedge mclk); #1;
    i_init_n = 1'b1;
    idle(3);
    chk("err_in_reset", err_cnt, 0);
    chk("rdy_fill", bus.o_rdy, 1'b1);
`ifdef FFT_STAGE_SCHED_STATS_EN
    chk("hold_cnt_rst", hold_cnt, 16'd0);
`endif

    // Spurious return while idle.
    inj_vld = 1'b1; inj_d = OUT_W'($urandom);
    idle(1);
    inj_vld = 1'b0;
    idle(3);
    chk("spurious_err", err_cnt, 1);
    chk("spurious_no_vld", n_out, 0);

    // Identity loopback, input 1..8.
    bf_dly = 0; bf_mix = 1'b0;
    for (int k = 1; k <= 2 * H; k++) put(IN_W'(k), IN_W'(-k));
    wait_quiet();
    chk("loop_count", n_out, 2 * H);

    // Back-to-back frames, 3-cycle butterfly: no HOLD, contiguous output.
    bf_dly = 3; bf_mix = 1'b1;
    n_out = 0; first_out = -1; rdy_low = 0;
    put_rand(4 * H, 1'b0);
    wait_quiet();
    chk("b2b_no_hold", rdy_low, 0);
    chk("b2b_count", n_out, 4 * H);
    chk("b2b_contig", last_out - first_out + 1, 4 * H);

    // 10-cycle butterfly, second frame's fill stretched into the first drain.
    bf_dly = 10;
    n_out = 0; rdy_low = 0;
`ifdef FFT_STAGE_SCHED_STATS_EN
    hb = int'(hold_cnt);
`else
    hb = 0;
`endif
    put_rand(2 * H, 1'b0);
    put_rand(H - 1, 1'b0);
    idle(9);
    put_rand(H + 1, 1'b0);
    wait_quiet();
    chk("hold_seen", (rdy_low > 0), 1'b1);
    chk("hold_count_out", n_out, 4 * H);
`ifdef FFT_STAGE_SCHED_STATS_EN
    chk("hold_cnt_val", int'(hold_cnt) - hb, rdy_low);
`endif

    // Reset in the middle of PAIR, then a clean frame.
    bf_dly = 2;
    e0 = err_cnt;
    put_rand(H + 2, 1'b0);
    i_init_n = 1'b0;
    idle(2);
    i_init_n = 1'b1;
    idle(2);
    n_out = 0;
    put_rand(2 * H, 1'b0);
    wait_quiet();
    chk("rst_mid_count", n_out, 2 * H);
    chk("rst_mid_no_err", err_cnt, e0);

    // Random 50% input gaps over several frames.
    n_out = 0;
    put_rand(8 * H, 1'b1);
    wait_quiet();
    chk("rand_count", n_out, 8 * H);
    chk("rand_no_err", err_cnt, e0);

`ifdef FFT_STAGE_SCHED_STATS_EN
    i_init_n = 1'b0;
    idle(1);
    i_init_n = 1'b1;
    idle(1);
    chk("hold_cnt_clear", hold_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
`default_nettype wire
